// File: rtl/pipelined_adder_pkg.sv
// Shared FSM state encoding and parameter defaults for the ap_ctrl_hs adder driver.
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    OUTPUT    = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int WD_WIDTH           = 16;

endpackage

// File: rtl/hls_watchdog.sv
// Cycle watchdog: asserts expired on the limit-th consecutive enabled cycle; clear restarts it.
// Only built with PIPELINED_ADDER_DRIVER_TIMEOUT_EN defined.
`ifdef PIPELINED_ADDER_DRIVER_TIMEOUT_EN
module hls_watchdog
  import pipelined_adder_pkg::*;
#(
  parameter int W = WD_WIDTH
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  // Combinational so the driver can leave its wait state on the very limit-th cycle.
  assign expired = enable && (count_q >= (limit - W'(1)));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/pipelined_adder_driver.sv
// Runs one ap_ctrl_hs job per accepted operand pair (accept->out_valid >= 2 cycles); in_ready only in IDLE,
// result held until out_ready. Optional watchdog under PIPELINED_ADDER_DRIVER_TIMEOUT_EN.
module pipelined_adder_driver
  import pipelined_adder_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_err,
  output logic                  acc_ap_start,
  input  logic                  acc_ap_done,
  input  logic                  acc_ap_idle,
  input  logic                  acc_ap_ready,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  input  logic [DATA_WIDTH-1:0] acc_sum,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  job_cnt
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [DATA_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                  out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  acc_ap_start_q, acc_ap_start_d;
  logic                  busy_q, busy_d;
  logic                  done_seen_q, done_seen_d;
  logic [CNT_WIDTH-1:0]  job_cnt_q, job_cnt_d;
  logic                  waiting;
  logic                  wd_expired;
  logic                  unused_cfg;

  assign waiting = (state_q == START) || (state_q == WAIT_DONE);

`ifdef PIPELINED_ADDER_DRIVER_TIMEOUT_EN
  hls_watchdog #(.W(WD_WIDTH)) u_watchdog (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .clear   (!waiting),
    .enable  (waiting),
    .limit   (WD_WIDTH'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );
  assign unused_cfg = acc_ap_idle;
`else
  assign wd_expired = 1'b0;
  assign unused_cfg = acc_ap_idle ^ TIMEOUT_CYCLES[0];
`endif

  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    done_seen_d = done_seen_q;
    job_cnt_d   = job_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_a_d     = in_a;
          acc_b_d     = in_b;
          done_seen_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        // An early done (before ready) is kept so the job completes once ready arrives.
        if (acc_ap_done) begin
          out_sum_d   = acc_sum;
          out_err_d   = 1'b0;
          done_seen_d = 1'b1;
        end
        if (acc_ap_ready) begin
          state_d = (acc_ap_done || done_seen_q) ? OUTPUT : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (acc_ap_done) begin
          out_sum_d = acc_sum;
          out_err_d = 1'b0;
          state_d   = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d   = IDLE;
          job_cnt_d = job_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A real completion in the expiry cycle wins over the timeout.
    if (wd_expired && waiting && (state_d != OUTPUT)) begin
      state_d   = OUTPUT;
      out_sum_d = '0;
      out_err_d = 1'b1;
    end
    acc_ap_start_d = (state_d == START);
    out_valid_d    = (state_d == OUTPUT);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= IDLE;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
      out_sum_q      <= '0;
      out_err_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      acc_ap_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_seen_q    <= 1'b0;
      job_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      acc_a_q        <= acc_a_d;
      acc_b_q        <= acc_b_d;
      out_sum_q      <= out_sum_d;
      out_err_q      <= out_err_d;
      out_valid_q    <= out_valid_d;
      acc_ap_start_q <= acc_ap_start_d;
      busy_q         <= busy_d;
      done_seen_q    <= done_seen_d;
      job_cnt_q      <= job_cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_err      = out_err_q;
  assign acc_ap_start = acc_ap_start_q;
  assign acc_a        = acc_a_q;
  assign acc_b        = acc_b_q;
  assign busy         = busy_q;
  assign job_cnt      = job_cnt_q;

endmodule

// File: tb/tb_pipelined_adder_driver.sv
// Directed bench for pipelined_adder_driver; timeout scenario on a second instance when the watchdog macro is set.
module tb_pipelined_adder_driver;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          in_ready, out_valid, out_err, busy;
  logic [DW-1:0] out_sum, acc_a, acc_b, acc_sum;
  logic          acc_ap_start, acc_ap_done, acc_ap_ready;
  logic [CW-1:0] job_cnt;

  // Accelerator: auto mode answers ready+done in the first start cycle with a+b.
  logic          auto_acc = 1'b0, man_ready = 1'b0, man_done = 1'b0;
  logic [DW-1:0] man_sum = '0;
  assign acc_ap_ready = auto_acc ? acc_ap_start : man_ready;
  assign acc_ap_done  = auto_acc ? acc_ap_start : man_done;
  assign acc_sum      = auto_acc ? (acc_a + acc_b) : man_sum;

  int n_asrt = 0;
  int n_fail = 0;
  int start_hi = 0;
  int base;
  int exp_cnt = 0;

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (acc_ap_start === 1'b1) start_hi++;

  pipelined_adder_driver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(64), .CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .acc_ap_start(acc_ap_start), .acc_ap_done(acc_ap_done), .acc_ap_idle(1'b1), .acc_ap_ready(acc_ap_ready),
    .acc_a(acc_a), .acc_b(acc_b), .acc_sum(acc_sum),
    .busy(busy), .job_cnt(job_cnt)
  );

`ifdef PIPELINED_ADDER_DRIVER_TIMEOUT_EN
  logic          t_in_valid = 1'b0, t_out_ready = 1'b0, t_done = 1'b0;
  logic          t_in_ready, t_out_valid, t_out_err, t_start, t_busy;
  logic [DW-1:0] t_out_sum, t_acc_a, t_acc_b;
  logic [CW-1:0] t_job_cnt;

  pipelined_adder_driver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)) dut_to (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(32'd1), .in_b(32'd2),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_sum(t_out_sum), .out_err(t_out_err),
    .acc_ap_start(t_start), .acc_ap_done(t_done), .acc_ap_idle(1'b0), .acc_ap_ready(1'b0),
    .acc_a(t_acc_a), .acc_b(t_acc_b), .acc_sum(32'hABCD_0123),
    .busy(t_busy), .job_cnt(t_job_cnt)
  );
`endif

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asrt++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_start", 64'(acc_ap_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_cnt", 64'(job_cnt), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_acc_a", 64'(acc_a), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    ap_rst = 1'b0;
    tick();

    // Minimum latency: 3 + 4
    auto_acc = 1'b1;
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4;
    check("lat_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("lat_start_n1", 64'(acc_ap_start), 64'd1);
    check("lat_busy_n1", 64'(busy), 64'd1);
    check("lat_acc_a", 64'(acc_a), 64'd3);
    check("lat_acc_b", 64'(acc_b), 64'd4);
    check("lat_valid_n1", 64'(out_valid), 64'd0);
    tick();
    check("lat_valid_n2", 64'(out_valid), 64'd1);
    check("lat_sum", 64'(out_sum), 64'd7);
    check("lat_err", 64'(out_err), 64'd0);
    check("lat_start_n2", 64'(acc_ap_start), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = 1;
    check("lat_valid_after", 64'(out_valid), 64'd0);
    check("lat_job_cnt", 64'(job_cnt), 64'(exp_cnt));
    check("lat_busy_after", 64'(busy), 64'd0);

    // Ready delayed 5 cycles, done 3 cycles later
    auto_acc = 1'b0;
    in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20;
    tick();
    in_valid = 1'b0;
    base = start_hi;
    for (int i = 1; i <= 5; i++) begin
      check("dly_start_hold", 64'(acc_ap_start), 64'd1);
      tick();
    end
    man_ready = 1'b1;
    check("dly_start_c6", 64'(acc_ap_start), 64'd1);
    tick();
    man_ready = 1'b0;
    check("dly_start_dropped", 64'(acc_ap_start), 64'd0);
    check("dly_busy_wait", 64'(busy), 64'd1);
    check("dly_valid_wait", 64'(out_valid), 64'd0);
    tick();
    tick();
    man_done = 1'b1; man_sum = 32'd30;
    check("dly_valid_pre_done", 64'(out_valid), 64'd0);
    tick();
    man_done = 1'b0; man_sum = 32'hDEAD;
    check("dly_valid", 64'(out_valid), 64'd1);
    check("dly_sum", 64'(out_sum), 64'd30);
    check("dly_start_cycles", 64'(start_hi - base), 64'd6);
    man_done = 1'b1; man_sum = 32'd99;
    tick();
    man_done = 1'b0;
    check("dly_sum_held", 64'(out_sum), 64'd30);
    check("dly_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = 2;
    check("dly_job_cnt", 64'(job_cnt), 64'(exp_cnt));
    check("dly_valid_after", 64'(out_valid), 64'd0);
    tick();
    check("dly_single_result", 64'(out_valid), 64'd0);
    check("dly_idle", 64'(busy), 64'd0);

    // Output backpressure for 10 cycles
    auto_acc = 1'b1;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFE; in_b = 32'd1;
    tick();
    in_a = 32'd5; in_b = 32'd6;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_sum_stable", 64'(out_sum), 64'hFFFF_FFFF);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_job_cnt", 64'(job_cnt), 64'(exp_cnt));
      tick();
    end
    in_valid = 1'b0;
    check("bp_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = 3;
    check("bp_job_cnt_after", 64'(job_cnt), 64'(exp_cnt));
    check("bp_acc_a_kept", 64'(acc_a), 64'hFFFF_FFFE);

    // Reset while in WAIT_DONE
    auto_acc = 1'b0;
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd8;
    tick();
    in_valid = 1'b0;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    check("rw_busy_wait", 64'(busy), 64'd1);
    check("rw_start_wait", 64'(acc_ap_start), 64'd0);
    ap_rst = 1'b1; man_done = 1'b1; man_sum = 32'd15;
    tick();
    check("rw_start", 64'(acc_ap_start), 64'd0);
    check("rw_valid", 64'(out_valid), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_job_cnt", 64'(job_cnt), 64'd0);
    check("rw_acc_a", 64'(acc_a), 64'd0);
    ap_rst = 1'b0;
    tick();
    man_done = 1'b0;
    check("rw_done_ignored", 64'(out_valid), 64'd0);
    check("rw_still_idle", 64'(busy), 64'd0);

    // 17 back-to-back jobs, 4-bit counter wraps to 1
    auto_acc = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd23;
    for (int t = 1; t <= 51; t++) begin
      tick();
      if (t == 45) check("wrap_cnt15", 64'(job_cnt), 64'd15);
      if (t == 48) check("wrap_cnt0", 64'(job_cnt), 64'd0);
      if (t == 50) check("wrap_sum", 64'(out_sum), 64'd123);
    end
    in_valid = 1'b0;
    check("wrap_cnt1", 64'(job_cnt), 64'd1);
    check("wrap_in_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    check("wrap_idle", 64'(busy), 64'd0);
    check("wrap_cnt_hold", 64'(job_cnt), 64'd1);

`ifdef PIPELINED_ADDER_DRIVER_TIMEOUT_EN
    // Watchdog: accelerator never ready, limit 8
    t_in_valid = 1'b1;
    tick();
    t_in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("to_start_hold", 64'(t_start), 64'd1);
      check("to_valid_low", 64'(t_out_valid), 64'd0);
      tick();
    end
    check("to_valid", 64'(t_out_valid), 64'd1);
    check("to_err", 64'(t_out_err), 64'd1);
    check("to_sum", 64'(t_out_sum), 64'd0);
    check("to_start_drop", 64'(t_start), 64'd0);
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    check("to_late_err", 64'(t_out_err), 64'd1);
    check("to_late_sum", 64'(t_out_sum), 64'd0);
    t_out_ready = 1'b1;
    tick();
    t_out_ready = 1'b0;
    t_done = 1'b1;
    check("to_job_cnt", 64'(t_job_cnt), 64'd1);
    check("to_valid_after", 64'(t_out_valid), 64'd0);
    tick();
    t_done = 1'b0;
    check("to_idle_done_ignored", 64'(t_busy), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
